// File: rtl/i2c_apb_sequencer_if.sv
// APB bus between the I2C register sequencer (master) and the APB I2C
// master peripheral (slave).
interface i2c_apb_sequencer_if #(
    parameter int APB_ADDR_WIDTH = 12
);
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/i2c_apb_sequencer.sv
// Runs single-byte I2C register writes / repeated-start reads by sequencing the
// APB I2C peripheral. Define I2C_SEQ_IRQ_WAIT_EN to wait on irq_i instead of polling.
module i2c_apb_sequencer #(
    parameter int                        APB_ADDR_WIDTH = 12,
    parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter logic [15:0]               PRESCALE       = 16'd99,
    parameter int                        TIMEOUT_CYCLES = 65535
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    i2c_apb_sequencer_if.master        apb,
`ifdef I2C_SEQ_IRQ_WAIT_EN
    input  logic                       irq_i,
`endif
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic                       req_rw_i,
    input  logic [6:0]                 req_dev_i,
    input  logic [7:0]                 req_reg_i,
    input  logic [7:0]                 req_wdata_i,
    output logic                       rsp_valid_o,
    output logic [7:0]                 rsp_rdata_o,
    output logic [1:0]                 rsp_err_o
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);
    localparam logic [APB_ADDR_WIDTH-1:0] A_PRE  = BASE_ADDR + APB_ADDR_WIDTH'('h00);
    localparam logic [APB_ADDR_WIDTH-1:0] A_CTRL = BASE_ADDR + APB_ADDR_WIDTH'('h04);
    localparam logic [APB_ADDR_WIDTH-1:0] A_RX   = BASE_ADDR + APB_ADDR_WIDTH'('h08);
    localparam logic [APB_ADDR_WIDTH-1:0] A_STAT = BASE_ADDR + APB_ADDR_WIDTH'('h0C);
    localparam logic [APB_ADDR_WIDTH-1:0] A_TX   = BASE_ADDR + APB_ADDR_WIDTH'('h10);
    localparam logic [APB_ADDR_WIDTH-1:0] A_CMD  = BASE_ADDR + APB_ADDR_WIDTH'('h14);
`ifdef I2C_SEQ_IRQ_WAIT_EN
    localparam logic [7:0] CTRL_VAL = 8'hC0;
`else
    localparam logic [7:0] CTRL_VAL = 8'h80;
`endif

    typedef enum logic [3:0] {
        S_INIT_PRE, S_INIT_CTRL, S_IDLE, S_TX, S_CMD, S_WAIT,
        S_AL_CLR, S_RCV_CMD, S_READ_RX, S_RESP
    } state_t;
    typedef enum logic [1:0] {PH_GAP, PH_SETUP, PH_ACC} phase_t;

    state_t              r_state, w_state_nxt;
    phase_t              r_phase, w_phase_nxt;
    logic [1:0]          r_step, w_step_nxt;
    logic                r_rcv, w_rcv_nxt;
    logic [TW-1:0]       r_tmo;
    logic [7:0]          r_rsp_rdata;
    logic [1:0]          r_rsp_err;
    logic                r_rw;
    logic [6:0]          r_dev;
    logic [7:0]          r_reg, r_wdata;

    logic                      w_tmo_hit, w_tmo_clr, w_rsp_ld, w_accept;
    logic [1:0]                w_rsp_err;
    logic [7:0]                w_rsp_rdata, w_tx_byte, w_cmd_byte;
    logic [APB_ADDR_WIDTH-1:0] w_addr;
    logic [31:0]               w_wdata;
    logic                      w_write, w_go, w_psel, w_penable, w_done;
    logic                      w_unused;

    assign w_tmo_hit = (r_tmo >= TMO_MAX);
    assign w_unused  = ^apb.PRDATA[31:8];

    // Step 2 is the data byte for writes and the repeated-start address for reads.
    always_comb begin
        w_tx_byte  = r_wdata;
        w_cmd_byte = 8'h69;
        case (r_step)
            2'd0: begin w_tx_byte = {r_dev, 1'b0}; w_cmd_byte = 8'h91; end
            2'd1: begin w_tx_byte = r_reg;         w_cmd_byte = 8'h11; end
            2'd2: begin
                w_tx_byte  = r_rw ? {r_dev, 1'b1} : r_wdata;
                w_cmd_byte = r_rw ? 8'h91 : 8'h51;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_step_nxt  = r_step;
        w_rcv_nxt   = r_rcv;
        w_tmo_clr   = 1'b0;
        w_rsp_ld    = 1'b0;
        w_rsp_err   = 2'b00;
        w_rsp_rdata = 8'h00;
        w_accept    = 1'b0;
        w_addr      = A_PRE;
        w_wdata     = '0;
        w_write     = 1'b0;
        w_go        = 1'b1;
        w_psel      = 1'b0;
        w_penable   = 1'b0;
        w_done      = 1'b0;

        case (r_state)
            S_INIT_PRE:  begin w_wdata = {16'h0, PRESCALE}; w_write = 1'b1; end
            S_INIT_CTRL: begin w_addr = A_CTRL; w_wdata = {24'h0, CTRL_VAL}; w_write = 1'b1; end
            S_TX:        begin w_addr = A_TX;   w_wdata = {24'h0, w_tx_byte};  w_write = 1'b1; end
            S_CMD:       begin w_addr = A_CMD;  w_wdata = {24'h0, w_cmd_byte}; w_write = 1'b1; end
            S_AL_CLR:    begin w_addr = A_CMD;  w_wdata = 32'h01; w_write = 1'b1; end
            S_RCV_CMD:   begin w_addr = A_CMD;  w_wdata = 32'h41; w_write = 1'b1; end
            S_READ_RX:   w_addr = A_RX;
`ifdef I2C_SEQ_IRQ_WAIT_EN
            S_WAIT:      begin w_addr = A_STAT; w_go = !w_tmo_hit && irq_i; end
`else
            S_WAIT:      begin w_addr = A_STAT; w_go = !w_tmo_hit; end
`endif
            default:     w_go = 1'b0;
        endcase

        // Shared APB engine: idle gap, SETUP, ACCESS until PREADY.
        case (r_phase)
            PH_GAP:   if (w_go) w_phase_nxt = PH_SETUP;
            PH_SETUP: begin w_psel = 1'b1; w_phase_nxt = PH_ACC; end
            PH_ACC: begin
                w_psel    = 1'b1;
                w_penable = 1'b1;
                if (apb.PREADY) begin
                    w_done      = 1'b1;
                    w_phase_nxt = PH_GAP;
                end
            end
            default:  w_phase_nxt = PH_GAP;
        endcase

        case (r_state)
            S_INIT_PRE:  if (w_done && !apb.PSLVERR) w_state_nxt = S_INIT_CTRL;
            S_INIT_CTRL: if (w_done && !apb.PSLVERR) w_state_nxt = S_IDLE;
            S_IDLE: if (req_valid_i) begin
                w_accept    = 1'b1;
                w_state_nxt = S_TX;
                w_phase_nxt = PH_SETUP;
                w_step_nxt  = 2'd0;
                w_rcv_nxt   = 1'b0;
            end
            S_TX, S_AL_CLR: if (w_done) begin
                if (apb.PSLVERR || r_state == S_AL_CLR) begin
                    w_state_nxt = S_RESP;
                    w_rsp_ld    = 1'b1;
                    w_rsp_err   = apb.PSLVERR ? 2'b11 : 2'b10;
                end else begin
                    w_state_nxt = S_CMD;
                end
            end
            S_CMD, S_RCV_CMD: if (w_done) begin
                if (apb.PSLVERR) begin
                    w_state_nxt = S_RESP;
                    w_rsp_ld    = 1'b1;
                    w_rsp_err   = 2'b11;
                end else begin
                    w_state_nxt = S_WAIT;
                    w_tmo_clr   = 1'b1;
                    w_rcv_nxt   = (r_state == S_RCV_CMD);
                end
            end
            S_WAIT: begin
                if (r_phase == PH_GAP && w_tmo_hit) begin
                    w_state_nxt = S_RESP;
                    w_phase_nxt = PH_GAP;
                    w_rsp_ld    = 1'b1;
                    w_rsp_err   = r_rcv ? 2'b01 : 2'b11;
                end else if (w_done) begin
                    if (apb.PSLVERR || (apb.PRDATA[0] && r_rcv)) begin
                        w_state_nxt = S_RESP;
                        w_rsp_ld    = 1'b1;
                        w_rsp_err   = apb.PSLVERR ? 2'b11 : 2'b01;
                    end else if (apb.PRDATA[0]) begin
                        // CHECK: arbitration loss wins over NACK; RXACK is meaningless on the RD step.
                        if (apb.PRDATA[5]) begin
                            w_state_nxt = S_AL_CLR;
                        end else if (apb.PRDATA[7] && r_step != 2'd3) begin
                            w_state_nxt = S_RCV_CMD;
                        end else if (r_step == 2'd3) begin
                            w_state_nxt = S_READ_RX;
                        end else if (r_step == 2'd2 && !r_rw) begin
                            w_state_nxt = S_RESP;
                            w_rsp_ld    = 1'b1;
                        end else begin
                            w_step_nxt  = r_step + 2'd1;
                            w_state_nxt = (r_step == 2'd2) ? S_CMD : S_TX;
                        end
                    end
                end
            end
            S_READ_RX: if (w_done) begin
                w_state_nxt = S_RESP;
                w_rsp_ld    = 1'b1;
                w_rsp_err   = apb.PSLVERR ? 2'b11 : 2'b00;
                w_rsp_rdata = apb.PSLVERR ? 8'h00 : apb.PRDATA[7:0];
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_INIT_PRE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= S_INIT_PRE;
            r_phase     <= PH_GAP;
            r_step      <= 2'd0;
            r_rcv       <= 1'b0;
            r_tmo       <= '0;
            r_rsp_rdata <= 8'h00;
            r_rsp_err   <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_step  <= w_step_nxt;
            r_rcv   <= w_rcv_nxt;
            if (w_tmo_clr)       r_tmo <= '0;
            else if (!w_tmo_hit) r_tmo <= r_tmo + TW'(1);
            if (w_rsp_ld) begin
                r_rsp_rdata <= w_rsp_rdata;
                r_rsp_err   <= w_rsp_err;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (w_accept) begin
            r_rw    <= req_rw_i;
            r_dev   <= req_dev_i;
            r_reg   <= req_reg_i;
            r_wdata <= req_wdata_i;
        end
    end

    assign apb.PSEL    = w_psel;
    assign apb.PENABLE = w_penable;
    assign apb.PWRITE  = w_psel & w_write;
    assign apb.PADDR   = w_psel ? w_addr : '0;
    assign apb.PWDATA  = (w_psel && w_write) ? w_wdata : 32'h0;
    assign req_ready_o = (r_state == S_IDLE);
    assign rsp_valid_o = (r_state == S_RESP);
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;
endmodule

// File: tb/tb_i2c_apb_sequencer.sv
// Directed bench for i2c_apb_sequencer: APB I2C peripheral model, table of
// transactions with hand-computed TX/CMD logs, plus init/timeout/error/reset sequences.
module tb_i2c_apb_sequencer;
    localparam int AW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req_valid, req_ready, req_rw, rsp_valid;
    logic [6:0] req_dev;
    logic [7:0] req_reg, req_wdata, rsp_rdata;
    logic [1:0] rsp_err;

    i2c_apb_sequencer_if #(.APB_ADDR_WIDTH(AW)) bus ();

    i2c_apb_sequencer #(
        .APB_ADDR_WIDTH(AW), .BASE_ADDR(12'h000), .PRESCALE(16'd99), .TIMEOUT_CYCLES(50)
    ) dut (
        .HCLK(clk), .HRESETn(rst_n), .apb(bus),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rw_i(req_rw),
        .req_dev_i(req_dev), .req_reg_i(req_reg), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
    );

    // Peripheral model controls (written by the test sequence only)
    int         nack_step = -1, al_step = -1, cmd_start = 0, pre_err_until = 0;
    logic [7:0] rx_byte = 8'h00;
    logic       never_if = 1'b0, ws_en = 1'b0, pslv_tx = 1'b0;

    // Peripheral model state (written by the model only)
    int              cyc = 0, polls = 0, pre_att = 0, cmd_cnt = 0, last_cmd_cyc = 0;
    logic            acc_first = 1'b0;
    logic [7:0]      txq[$], cmdq[$];
    logic [AW-1:0]   wa[$];
    logic [31:0]     wd[$];

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        acc_first <= bus.PSEL && !bus.PENABLE;
        if (bus.PSEL && bus.PENABLE && bus.PREADY) begin
            if (bus.PADDR == 12'h000) pre_att <= pre_att + 1;
            if (bus.PWRITE && !bus.PSLVERR) begin
                wa.push_back(bus.PADDR);
                wd.push_back(bus.PWDATA);
                if (bus.PADDR == 12'h010) txq.push_back(bus.PWDATA[7:0]);
                if (bus.PADDR == 12'h014) begin
                    cmdq.push_back(bus.PWDATA[7:0]);
                    cmd_cnt      <= cmd_cnt + 1;
                    polls        <= 0;
                    last_cmd_cyc <= cyc;
                end
            end
            if (!bus.PWRITE && bus.PADDR == 12'h00C) polls <= polls + 1;
        end
    end

    assign bus.PREADY = !ws_en || !acc_first;

    int         cur_step;
    logic [7:0] stat;
    always_comb begin
        cur_step = cmd_cnt - cmd_start - 1;
        stat     = 8'h00;
        if (!never_if && polls > 0)
            stat = {(cur_step == nack_step), 1'b0, (cur_step == al_step), 4'b0000, 1'b1};
        bus.PRDATA = 32'h0;
        if (bus.PADDR == 12'h00C)      bus.PRDATA = {24'h0, stat};
        else if (bus.PADDR == 12'h008) bus.PRDATA = {24'h0, rx_byte};
        bus.PSLVERR = bus.PSEL && bus.PENABLE &&
                      ((pslv_tx && bus.PADDR == 12'h010) ||
                       (bus.PADDR == 12'h000 && pre_att < pre_err_until));
    end

    int n_chk = 0, n_pass = 0;
    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic rst_check(input string nm);
        check(nm, {5'b0, bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA,
                   req_ready, rsp_valid, rsp_rdata, rsp_err}, 64'h0);
    endtask

    task automatic init_check(input string tag, input int w0, input int pre0, input int exp_pre);
        int k = 0;
        while (!req_ready && k < 100) begin @(negedge clk); k++; end
        check({tag, " ready"}, 64'(req_ready), 64'd1);
        repeat (4) @(negedge clk);
        check({tag, " nwr"}, 64'(wa.size() - w0), 64'd2);
        if (wa.size() >= w0 + 2) begin
            check({tag, " pre"},  {20'h0, wa[w0],     wd[w0]},     {20'h0, 12'h000, 32'd99});
            check({tag, " ctrl"}, {20'h0, wa[w0 + 1], wd[w0 + 1]}, {20'h0, 12'h004, 32'h80});
        end
        check({tag, " pre_attempts"}, 64'(pre_att - pre0), 64'(exp_pre));
    endtask

    typedef struct {
        logic       rw;
        logic [6:0] dev;
        logic [7:0] rg, wd, rx;
        int         nack, al;
        logic       ws;
        int         ntx;
        logic [31:0] tx;
        int         ncmd;
        logic [31:0] cmd;
        logic [1:0] err;
        logic [7:0] rdata;
    } vec_t;

    function automatic vec_t mk(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                                input logic [7:0] wdv, input logic [7:0] rx, input int nack,
                                input int al, input logic ws, input int ntx, input logic [31:0] tx,
                                input int ncmd, input logic [31:0] cmd, input logic [1:0] err,
                                input logic [7:0] rdata);
        vec_t v;
        v.rw = rw; v.dev = dev; v.rg = rg; v.wd = wdv; v.rx = rx; v.nack = nack; v.al = al;
        v.ws = ws; v.ntx = ntx; v.tx = tx; v.ncmd = ncmd; v.cmd = cmd; v.err = err; v.rdata = rdata;
        return v;
    endfunction

    int rsp_at = 0;

    task automatic run_txn(input vec_t v, input string tag);
        int k, tx0;
        logic [31:0] atx, acmd;
        nack_step = v.nack; al_step = v.al; rx_byte = v.rx; ws_en = v.ws;
        k = 0;
        while (!req_ready && k < 200) begin @(negedge clk); k++; end
        check({tag, " ready"}, 64'(req_ready), 64'd1);
        tx0 = txq.size();
        cmd_start = cmd_cnt;
        req_rw = v.rw; req_dev = v.dev; req_reg = v.rg; req_wdata = v.wd; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_rw = ~v.rw; req_dev = ~v.dev; req_reg = ~v.rg; req_wdata = ~v.wd;
        check({tag, " accepted"}, 64'(req_ready), 64'd0);
        k = 0;
        while (!rsp_valid && k < 400) begin
            req_valid = (k == 1 || k == 2);
            @(negedge clk);
            k++;
        end
        req_valid = 1'b0;
        rsp_at = cyc;
        check({tag, " rsp_seen"}, 64'(rsp_valid), 64'd1);
        check({tag, " err"},   64'(rsp_err),   64'(v.err));
        check({tag, " rdata"}, 64'(rsp_rdata), 64'(v.rdata));
        @(negedge clk);
        check({tag, " one_cycle"}, {62'h0, rsp_valid, req_ready}, 64'b01);
        atx = 32'h0;
        for (int i = tx0; i < txq.size(); i++) atx = (atx << 8) | 32'(txq[i]);
        acmd = 32'h0;
        for (int i = cmd_start; i < cmdq.size(); i++) acmd = (acmd << 8) | 32'(cmdq[i]);
        check({tag, " tx"},  {32'(txq.size() - tx0), atx},         {32'(v.ntx), v.tx});
        check({tag, " cmd"}, {32'(cmdq.size() - cmd_start), acmd}, {32'(v.ncmd), v.cmd});
        nack_step = -1; al_step = -1; ws_en = 1'b0;
    endtask

    vec_t vt[8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, w0, pre0, lat;
        vt[0] = mk(0, 7'h50, 8'h10, 8'hA5, 8'h00, -1, -1, 0, 3, 32'h00A010A5, 3, 32'h00911151, 2'b00, 8'h00);
        vt[1] = mk(1, 7'h50, 8'h02, 8'h00, 8'h3C, -1, -1, 1, 3, 32'h00A002A1, 4, 32'h91119169, 2'b00, 8'h3C);
        vt[2] = mk(0, 7'h50, 8'h10, 8'hA5, 8'h00,  0, -1, 0, 1, 32'h000000A0, 2, 32'h00009141, 2'b01, 8'h00);
        vt[3] = mk(1, 7'h50, 8'h02, 8'h00, 8'h3C, -1,  0, 0, 1, 32'h000000A0, 2, 32'h00009101, 2'b10, 8'h00);
        vt[4] = mk(0, 7'h1A, 8'hFF, 8'h00, 8'h00,  2, -1, 1, 3, 32'h0034FF00, 4, 32'h91115141, 2'b01, 8'h00);
        vt[5] = mk(1, 7'h7F, 8'h80, 8'h00, 8'h55,  1, -1, 0, 2, 32'h0000FE80, 3, 32'h00911141, 2'b01, 8'h00);
        vt[6] = mk(1, 7'h21, 8'h33, 8'h00, 8'hC3,  3, -1, 1, 3, 32'h00423343, 4, 32'h91119169, 2'b00, 8'hC3);
        vt[7] = mk(1, 7'h50, 8'h02, 8'h00, 8'h3C, -1,  2, 0, 3, 32'h00A002A1, 4, 32'h91119101, 2'b10, 8'h00);

        rst_n = 1'b0; req_valid = 1'b0; req_rw = 1'b0;
        req_dev = 7'h0; req_reg = 8'h0; req_wdata = 8'h0;
        repeat (3) @(negedge clk);
        rst_check("reset_values");

        // Requests raised during init must not be accepted.
        pre_err_until = 0;
        rst_n = 1'b1; req_valid = 1'b1; req_rw = 1'b0; req_dev = 7'h11; req_reg = 8'h22;
        repeat (3) @(negedge clk);
        req_valid = 1'b0;
        init_check("init", 0, 0, 1);

        for (int i = 0; i < 8; i++) run_txn(vt[i], $sformatf("vec%0d", i));

        never_if = 1'b1;
        run_txn(mk(0, 7'h50, 8'h10, 8'hA5, 8'h00, -1, -1, 0, 1, 32'h000000A0, 1, 32'h00000091, 2'b11, 8'h00), "timeout");
        never_if = 1'b0;
        lat = rsp_at - last_cmd_cyc;
        check("timeout_latency", 64'(lat >= 50 && lat <= 60), 64'd1);

        pslv_tx = 1'b1;
        run_txn(mk(1, 7'h50, 8'h02, 8'h00, 8'h3C, -1, -1, 0, 0, 32'h0, 0, 32'h0, 2'b11, 8'h00), "pslverr_tx");
        pslv_tx = 1'b0;

        run_txn(vt[1], "pre_midreset");
        rx_byte = 8'h77;
        k = 0;
        while (!req_ready && k < 100) begin @(negedge clk); k++; end
        req_rw = 1'b1; req_dev = 7'h50; req_reg = 8'h02; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        pre0 = pre_att;
        pre_err_until = pre_att + 1;
        w0 = wa.size();
        rst_n = 1'b0;
        #1;
        rst_check("midread_reset_values");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        init_check("reinit", w0, pre0, 2);

        run_txn(vt[0], "post_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
